coin_feeder: RTL

- Payment initiator that drives the vending machine's coin interface.
- On `start` it latches a wallet (counts of high- and low-value coins) and serially issues single-cycle coin strobes until the machine's price is covered.
- It then waits for `is_dispensed` and reports done or fail.
- It acts as the stimulus/transmitter end for the vending-machine receiver in system-level benches and in the top-level integration.

---
 rtl/orange_pkg.sv | 29 ++
 rtl/coin_feeder_if.sv | 33 +++
 rtl/coin_select.sv | 43 ++++
 rtl/coin_feeder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/orange_pkg.sv
// Shared definitions for the coin feeder and the vending machine it drives:
// FSM state encoding, coin-type encoding and default coin values.
package orange_pkg;

  // FSM state encoding, also exported on the debug state output
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_SEND      = 3'd1;
  localparam state_t ST_GAP       = 3'd2;
  localparam state_t ST_WAIT_DISP = 3'd3;
  localparam state_t ST_DONE      = 3'd4;
  localparam state_t ST_FAIL      = 3'd5;

  // Coin-type encoding on the coin_type line
  localparam logic COIN_LO = 1'b0;
  localparam logic COIN_HI = 1'b1;

  // Default coin values and price, shared so both ends agree
  localparam int DEF_LO_VAL = 5;
  localparam int DEF_HI_VAL = 10;
  localparam int DEF_PRICE  = 15;

  // Every state except IDLE counts as busy
  function automatic logic state_is_busy(input state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/coin_feeder_if.sv
// Payment/coin bus between the coin feeder and its environment.
// The feeder takes the master view; the environment (wallet, vending
// machine, bench) takes the slave view.
interface coin_feeder_if #(
  parameter int CNT_W = 4,
  parameter int AMT_W = 8
);
  // Payment request and wallet contents
  logic             start;
  logic [CNT_W-1:0] hi_avail;
  logic [CNT_W-1:0] lo_avail;
  // Dispense indication from the vending machine
  logic             is_dispensed;
  // Coin strobe toward the vending machine
  logic             coin_valid;
  logic             coin_type;
  // Status
  logic             busy;
  logic             done;
  logic             fail;
  logic [AMT_W-1:0] paid;
  logic [2:0]       state;

  modport master (
    input  start, hi_avail, lo_avail, is_dispensed,
    output coin_valid, coin_type, busy, done, fail, paid, state
  );

  modport slave (
    output start, hi_avail, lo_avail, is_dispensed,
    input  coin_valid, coin_type, busy, done, fail, paid, state
  );
endinterface

// File: rtl/coin_select.sv
// Combinational coin chooser: given the remaining amount and the coins
// left in the wallet, pick the next coin to send (or none).
module coin_select
  import orange_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int AMT_W  = 8,
  parameter int LO_VAL = DEF_LO_VAL,
  parameter int HI_VAL = DEF_HI_VAL
) (
  input  logic [AMT_W-1:0] i_rem,
  input  logic [CNT_W-1:0] i_hi,
  input  logic [CNT_W-1:0] i_lo,
  output logic             o_send,
  output logic             o_type,
  output logic [AMT_W-1:0] o_value
);

  localparam logic [AMT_W-1:0] LO_AMT = AMT_W'(LO_VAL);
  localparam logic [AMT_W-1:0] HI_AMT = AMT_W'(HI_VAL);

  // Prefer a high coin that does not overshoot, then low coins, then an
  // overpaying high coin; with an empty wallet nothing is sent.
  always_comb begin
    o_send  = 1'b0;
    o_type  = COIN_LO;
    o_value = '0;
    if ((i_rem >= HI_AMT) && (i_hi != '0)) begin
      o_send  = 1'b1;
      o_type  = COIN_HI;
      o_value = HI_AMT;
    end else if (i_lo != '0) begin
      o_send  = 1'b1;
      o_type  = COIN_LO;
      o_value = LO_AMT;
    end else if (i_hi != '0) begin
      o_send  = 1'b1;
      o_type  = COIN_HI;
      o_value = HI_AMT;
    end
  end

endmodule

// File: rtl/coin_feeder.sv
// Coin feeder: latches a wallet on start, strobes coins one at a time with
// an idle cycle between them until the price is covered, then waits a
// bounded time for the machine to dispense and reports done or fail.
// All outputs come straight from registers, so the coin choice is made on
// the transition into SEND and the strobe is visible during SEND itself.
module coin_feeder
  import orange_pkg::*;
#(
  parameter int PRICE   = DEF_PRICE,
  parameter int LO_VAL  = DEF_LO_VAL,
  parameter int HI_VAL  = DEF_HI_VAL,
  parameter int CNT_W   = 4,
  parameter int AMT_W   = 8,
  parameter int TIMEOUT = 8
) (
  input logic           clk,
  input logic           rst,
  coin_feeder_if.master bus
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AMT_W-1:0] PRICE_AMT = AMT_W'(PRICE);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  // State and latched payment context
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_hi;
  logic [CNT_W-1:0] r_lo;
  logic [AMT_W-1:0] r_paid;
  logic [AMT_W-1:0] r_coin_amt;
  logic [TMO_W-1:0] r_tmo;

  // Registered outputs
  logic r_coin_valid;
  logic r_coin_type;
  logic r_busy;
  logic r_done;
  logic r_fail;

  // Coin chooser inputs/outputs
  logic [AMT_W-1:0] w_sel_rem;
  logic [CNT_W-1:0] w_sel_hi;
  logic [CNT_W-1:0] w_sel_lo;
  logic             w_sel_send;
  logic             w_sel_type;
  logic [AMT_W-1:0] w_sel_value;

  logic             w_accept;
  logic             w_sent;
  logic             w_enter_send;
  logic [AMT_W:0]   w_paid_sum;

  assign w_accept     = (r_state == ST_IDLE) && bus.start;
  assign w_sent       = (r_state == ST_SEND) && r_coin_valid;
  assign w_enter_send = (w_state_next == ST_SEND);
  assign w_paid_sum   = {1'b0, r_paid} + {1'b0, r_coin_amt};

  // Chooser sees the view that will hold in SEND: fresh wallet from IDLE,
  // latched counts and current total when coming back from GAP.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_sel_rem = PRICE_AMT;
      w_sel_hi  = bus.hi_avail;
      w_sel_lo  = bus.lo_avail;
    end else begin
      w_sel_rem = PRICE_AMT - r_paid;
      w_sel_hi  = r_hi;
      w_sel_lo  = r_lo;
    end
  end

  coin_select #(
    .CNT_W  (CNT_W),
    .AMT_W  (AMT_W),
    .LO_VAL (LO_VAL),
    .HI_VAL (HI_VAL)
  ) u_coin_select (
    .i_rem   (w_sel_rem),
    .i_hi    (w_sel_hi),
    .i_lo    (w_sel_lo),
    .o_send  (w_sel_send),
    .o_type  (w_sel_type),
    .o_value (w_sel_value)
  );

  // Next-state logic; dispense takes priority over timeout expiry
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (bus.start) w_state_next = ST_SEND;
      ST_SEND:      w_state_next = r_coin_valid ? ST_GAP : ST_FAIL;
      ST_GAP:       w_state_next = (r_paid >= PRICE_AMT) ? ST_WAIT_DISP : ST_SEND;
      ST_WAIT_DISP: begin
        if (bus.is_dispensed)       w_state_next = ST_DONE;
        else if (r_tmo == TMO_LAST) w_state_next = ST_FAIL;
      end
      ST_DONE:      w_state_next = ST_IDLE;
      ST_FAIL:      w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // State register plus busy/done/fail flags derived from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= state_is_busy(w_state_next);
      r_done  <= (w_state_next == ST_DONE);
      r_fail  <= (w_state_next == ST_FAIL);
    end
  end

  // Coin strobe: decided on entry to SEND so it is registered during SEND
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_coin_valid <= 1'b0;
      r_coin_type  <= COIN_LO;
      r_coin_amt   <= '0;
    end else if (w_enter_send && w_sel_send) begin
      r_coin_valid <= 1'b1;
      r_coin_type  <= w_sel_type;
      r_coin_amt   <= w_sel_value;
    end else begin
      r_coin_valid <= 1'b0;
      r_coin_type  <= COIN_LO;
    end
  end

  // Wallet counts and running total; total saturates and holds after the payment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_paid <= '0;
    end else if (w_accept) begin
      r_hi   <= bus.hi_avail;
      r_lo   <= bus.lo_avail;
      r_paid <= '0;
    end else if (w_sent) begin
      if (r_coin_type == COIN_HI) r_hi <= r_hi - 1'b1;
      else                        r_lo <= r_lo - 1'b1;
      r_paid <= w_paid_sum[AMT_W] ? {AMT_W{1'b1}} : w_paid_sum[AMT_W-1:0];
    end
  end

  // Dispense timeout counter, running only while waiting for the machine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= '0;
    end else if (r_state == ST_WAIT_DISP) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

  assign bus.coin_valid = r_coin_valid;
  assign bus.coin_type  = r_coin_type;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.fail       = r_fail;
  assign bus.paid       = r_paid;
  assign bus.state      = r_state;

endmodule
